rll_key_loader: RTL and testbench

- Sequential successor to our fixed 32-bit random-logic-locking key gates.
- Parametrised in key width, channel count and key-gate polarity.
- Loads the key serially through a handshake into a shadow register, then commits it atomically.
- Applies the committed key to CHANNELS data lanes through a registered XOR/XNOR mask stage. A saturating load counter freezes the block after MAX_LOADS commits.

---
 rtl/rll_key_loader.sv | 148 ++++++++++++++
 tb/tb_rll_key_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_loader.sv
// Sequential random-logic-locking key loader: serial handshake load into a shadow
// register, atomic commit, and a registered per-lane XOR/XNOR key-gate mask stage.
module rll_key_loader #(
  parameter int unsigned          KEY_WIDTH = 32,
  parameter int unsigned          CHANNELS  = 1,
  parameter logic [KEY_WIDTH-1:0] POLARITY  = '0,
  parameter int unsigned          ROT_STEP  = 1,
  parameter int unsigned          MAX_LOADS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_start,
  input  logic                          key_abort,
  input  logic                          key_in_valid,
  input  logic                          key_in_bit,
  output logic                          key_in_ready,
  output logic                          key_loaded,
  output logic [7:0]                    load_count,
  output logic                          frozen,
  input  logic                          data_in_valid,
  input  logic [CHANNELS*KEY_WIDTH-1:0] data_in,
  output logic                          data_out_valid,
  output logic [CHANNELS*KEY_WIDTH-1:0] data_out
);

  localparam int unsigned          CNT_W    = $clog2(KEY_WIDTH);
  localparam int unsigned          DATA_W   = CHANNELS * KEY_WIDTH;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(KEY_WIDTH - 1);
  localparam logic [7:0]           MAX_CNT  = 8'(MAX_LOADS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, FROZEN} state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] shift_q, shift_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           load_count_q, load_count_d;
  logic                 key_loaded_q, key_loaded_d;
  logic                 ready_q, ready_d;
  logic                 frozen_q, frozen_d;
  logic                 dout_valid_q;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic [DATA_W-1:0]    mask_c;
  logic [7:0]           count_inc_c;

  function automatic logic [KEY_WIDTH-1:0] rotl(input logic [KEY_WIDTH-1:0] x,
                                                input int unsigned amt);
    rotl = (amt == 0) ? x : ((x << amt) | (x >> (KEY_WIDTH - amt)));
  endfunction

  assign count_inc_c = (load_count_q == 8'hFF) ? load_count_q : load_count_q + 8'd1;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      key_q        <= '0;
      bit_cnt_q    <= '0;
      load_count_q <= '0;
      key_loaded_q <= 1'b0;
      ready_q      <= 1'b0;
      frozen_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      key_q        <= key_d;
      bit_cnt_q    <= bit_cnt_d;
      load_count_q <= load_count_d;
      key_loaded_q <= key_loaded_d;
      ready_q      <= ready_d;
      frozen_q     <= frozen_d;
      dout_valid_q <= data_in_valid;
      dout_q       <= dout_d;
    end
  end

  // Next-state: abort beats restart, restart beats an incoming bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (key_start && !key_abort) state_d = SHIFT;
      SHIFT: begin
        if (key_abort)                                  state_d = IDLE;
        else if (!key_start && key_in_valid &&
                 bit_cnt_q == LAST_BIT)                 state_d = COMMIT;
      end
      COMMIT: state_d = (count_inc_c == MAX_CNT) ? FROZEN : IDLE;
      FROZEN: state_d = FROZEN;
      default: state_d = IDLE;
    endcase
  end

  // Shadow register, commit and status outputs
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    key_d        = key_q;
    load_count_d = load_count_q;
    key_loaded_d = key_loaded_q;
    ready_d      = (state_d == SHIFT);
    frozen_d     = (state_d == FROZEN);
    unique case (state_q)
      IDLE: begin
        if (key_start && !key_abort) begin
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!key_abort && key_start) begin
          shift_d   = '0;
          bit_cnt_d = '0;
        end else if (!key_abort && key_in_valid) begin
          shift_d   = {shift_q[KEY_WIDTH-2:0], key_in_bit};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        key_d        = shift_q;
        key_loaded_d = 1'b1;
        load_count_d = count_inc_c;
      end
      default: ;
    endcase
  end

  // Per-lane mask: rotl(K ^ POLARITY) equals rotl(K) ^ rotl(POLARITY)
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam int unsigned AMT = (int'(c) * ROT_STEP) % KEY_WIDTH;
    assign mask_c[c*KEY_WIDTH +: KEY_WIDTH] = rotl(key_q ^ POLARITY, AMT);
  end

  always_comb begin
    dout_d = dout_q;
    if (data_in_valid) dout_d = data_in ^ mask_c;
  end

  assign key_in_ready   = ready_q;
  assign key_loaded     = key_loaded_q;
  assign load_count     = load_count_q;
  assign frozen         = frozen_q;
  assign data_out_valid = dout_valid_q;
  assign data_out       = dout_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Bench for rll_key_loader: two instances (2-lane rotating XOR, 1-lane mixed
// polarity with MAX_LOADS=2) sharing stimulus, checked against a behavioural model.
module tb_rll_key_loader;

  localparam logic [31:0] P_A = 32'h0000_0000;
  localparam logic [31:0] P_B = 32'h0000_FFFF;

  logic        clk, rst_n;
  logic        key_start, key_abort, key_in_valid, key_in_bit;
  logic        data_in_valid;
  logic [63:0] data_in;

  logic        ready_a, loaded_a, frz_a, dov_a;
  logic [7:0]  cnt_a;
  logic [63:0] dout_a;
  logic        ready_b, loaded_b, frz_b, dov_b;
  logic [7:0]  cnt_b;
  logic [31:0] dout_b;

  int n_tests = 0;
  int n_fail  = 0;

  rll_key_loader #(.KEY_WIDTH(32), .CHANNELS(2), .POLARITY(P_A), .ROT_STEP(4),
                   .MAX_LOADS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_abort(key_abort),
    .key_in_valid(key_in_valid), .key_in_bit(key_in_bit), .key_in_ready(ready_a),
    .key_loaded(loaded_a), .load_count(cnt_a), .frozen(frz_a),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .data_out_valid(dov_a), .data_out(dout_a));

  rll_key_loader #(.KEY_WIDTH(32), .CHANNELS(1), .POLARITY(P_B), .ROT_STEP(1),
                   .MAX_LOADS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_abort(key_abort),
    .key_in_valid(key_in_valid), .key_in_bit(key_in_bit), .key_in_ready(ready_b),
    .key_loaded(loaded_b), .load_count(cnt_b), .frozen(frz_b),
    .data_in_valid(data_in_valid), .data_in(data_in[31:0]),
    .data_out_valid(dov_b), .data_out(dout_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 loading, 2 commit pending, 3 frozen
  int          m_mode   [2];
  int          m_n      [2];
  logic [31:0] m_acc    [2];
  logic [31:0] m_key    [2];
  logic [7:0]  m_cnt    [2];
  logic        m_loaded [2];
  logic        m_dov    [2];
  logic [63:0] m_dout   [2];

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [63:0] masked(input int d, input logic [63:0] din);
    logic [63:0] r;
    logic [31:0] p;
    int nch, rot, a;
    r   = '0;
    nch = (d == 0) ? 2 : 1;
    rot = (d == 0) ? 4 : 1;
    p   = (d == 0) ? P_A : P_B;
    for (int c = 0; c < nch; c++) begin
      a = (c * rot) % 32;
      r[c*32 +: 32] = din[c*32 +: 32] ^ rotl32(m_key[d], a) ^ rotl32(p, a);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_n[d] = 0; m_acc[d] = '0; m_key[d] = '0;
      m_cnt[d] = '0; m_loaded[d] = 1'b0; m_dov[d] = 1'b0; m_dout[d] = '0;
    end
  endtask

  task automatic model_step(input int d);
    int maxl;
    maxl = (d == 0) ? 4 : 2;
    if (data_in_valid) m_dout[d] = masked(d, data_in);
    m_dov[d] = data_in_valid;
    case (m_mode[d])
      0: if (key_start && !key_abort) begin
           m_mode[d] = 1; m_acc[d] = '0; m_n[d] = 0;
         end
      1: if (key_abort) m_mode[d] = 0;
         else if (key_start) begin
           m_acc[d] = '0; m_n[d] = 0;
         end else if (key_in_valid) begin
           m_acc[d] = (m_acc[d] << 1) | 32'(key_in_bit);
           m_n[d]++;
           if (m_n[d] == 32) m_mode[d] = 2;
         end
      2: begin
           m_key[d] = m_acc[d];
           if (m_cnt[d] != 8'hFF) m_cnt[d] = m_cnt[d] + 8'd1;
           m_loaded[d] = 1'b1;
           m_mode[d] = (int'(m_cnt[d]) == maxl) ? 3 : 0;
         end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic rdy, input logic ld, input logic [7:0] cnt,
                           input logic frz, input logic dov, input logic [63:0] dout);
    string s;
    s = (d == 0) ? "a" : "b";
    chk({"ready_", s},  64'(rdy),  64'(m_mode[d] == 1));
    chk({"loaded_", s}, 64'(ld),   64'(m_loaded[d]));
    chk({"count_", s},  64'(cnt),  64'(m_cnt[d]));
    chk({"frozen_", s}, 64'(frz),  64'(m_mode[d] == 3));
    chk({"dov_", s},    64'(dov),  64'(m_dov[d]));
    chk({"dout_", s},   dout,      m_dout[d]);
  endtask

  task automatic check_all();
    check_dut(0, ready_a, loaded_a, cnt_a, frz_a, dov_a, dout_a);
    check_dut(1, ready_b, loaded_b, cnt_b, frz_b, dov_b, {32'h0, dout_b});
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    key_start = 1'b0; key_abort = 1'b0; key_in_valid = 1'b0; key_in_bit = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] k);
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      key_in_valid = 1'b1;
      key_in_bit   = k[i];
      step();
    end
    key_in_valid = 1'b0;
    step();
  endtask

  task automatic send(input logic [63:0] d);
    data_in_valid = 1'b1;
    data_in       = d;
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] key;
    logic [63:0] din;
    logic [63:0] exp_a;
    logic [31:0] exp_b;
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;
    logic        frz_b;
  } vec_t;

  vec_t vt [3];

  initial begin
    vt[0] = '{32'h0000FFFF, 64'h00000000_12345678, 64'h000FFFF0_1234A987, 32'h12345678, 8'd1, 8'd1, 1'b0};
    vt[1] = '{32'h00000000, 64'h00000000_12345678, 64'h00000000_12345678, 32'h1234A987, 8'd2, 8'd2, 1'b1};
    vt[2] = '{32'h0000000F, 64'h00000000_00000000, 64'h000000F0_0000000F, 32'h0000FFFF, 8'd3, 8'd2, 1'b1};

    idle_inputs();
    data_in = '0;
    rst_n   = 1'b1;
    model_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_a", 64'(ready_a), 64'd0);
    chk("rst_loaded_a", 64'(loaded_a), 64'd0);
    chk("rst_count_b", 64'(cnt_b), 64'd0);
    chk("rst_dout_a", dout_a, 64'd0);
    check_all();
    rst_n = 1'b1;

    // Unkeyed passthrough on the all-XOR instance
    send({32'h0, 32'hDEADBEEF});
    chk("plain_a", dout_a, 64'h00000000_DEADBEEF);
    chk("plain_b", 64'(dout_b), 64'h00000000_DEAD4110);
    chk("plain_loaded", 64'(loaded_a), 64'd0);

    for (int i = 0; i < 3; i++) begin
      load_key(vt[i].key);
      send(vt[i].din);
      chk("tbl_dout_a", dout_a, vt[i].exp_a);
      chk("tbl_dout_b", 64'(dout_b), 64'(vt[i].exp_b));
      chk("tbl_cnt_a", 64'(cnt_a), 64'(vt[i].cnt_a));
      chk("tbl_cnt_b", 64'(cnt_b), 64'(vt[i].cnt_b));
      chk("tbl_frz_b", 64'(frz_b), 64'(vt[i].frz_b));
    end

    data_in = {$urandom, $urandom};
    step();
    chk("hold_dout_a", dout_a, 64'h000000F0_0000000F);
    chk("hold_dov_a", 64'(dov_a), 64'd0);

    do_reset();

    // Abort after 10 bits, restart at bit 20, then a full load
    key_start = 1'b1; step(); key_start = 1'b0;
    for (int i = 0; i < 10; i++) begin key_in_valid = 1'b1; key_in_bit = 1'b1; step(); end
    key_abort = 1'b1; step(); key_abort = 1'b0;
    chk("abort_ready", 64'(ready_a), 64'd0);
    chk("abort_cnt", 64'(cnt_a), 64'd0);
    key_in_valid = 1'b0;
    key_start = 1'b1; step(); key_start = 1'b0;
    for (int i = 0; i < 20; i++) begin key_in_valid = 1'b1; key_in_bit = 1'b1; step(); end
    key_start = 1'b1; step(); key_start = 1'b0;
    chk("restart_ready", 64'(ready_a), 64'd1);
    begin
      logic [31:0] k;
      k = 32'hA5A5A5A5;
      for (int i = 31; i >= 1; i--) begin key_in_valid = 1'b1; key_in_bit = k[i]; step(); end
      chk("restart_not_loaded", 64'(loaded_a), 64'd0);
      chk("restart_still_ready", 64'(ready_a), 64'd1);
      key_in_bit = k[0]; step();
    end
    chk("commit_ready", 64'(ready_a), 64'd0);
    key_in_valid = 1'b0;
    step();
    chk("restart_cnt_a", 64'(cnt_a), 64'd1);
    chk("restart_loaded_a", 64'(loaded_a), 64'd1);
    send(64'h0);
    chk("restart_key_a", dout_a, 64'h5A5A5A5A_A5A5A5A5);
    chk("restart_key_b", 64'(dout_b), 64'h00000000_A5A55A5A);

    key_start = 1'b1; key_abort = 1'b1; step(); idle_inputs();
    chk("start_abort_idle", 64'(ready_a), 64'd0);

    load_key(32'h00000001);
    chk("freeze_b", 64'(frz_b), 64'd1);
    chk("nofreeze_a", 64'(frz_a), 64'd0);
    key_start = 1'b1; step(); key_start = 1'b0;
    chk("frozen_ready_b", 64'(ready_b), 64'd0);
    chk("live_ready_a", 64'(ready_a), 64'd1);
    key_abort = 1'b1; step(); key_abort = 1'b0;

    // Reset mid-load with data in flight
    key_start = 1'b1; step(); key_start = 1'b0;
    for (int i = 0; i < 5; i++) begin key_in_valid = 1'b1; key_in_bit = 1'b0; step(); end
    data_in_valid = 1'b1; data_in = {$urandom, $urandom}; step();
    rst_n = 1'b0;
    #1;
    chk("midrst_dout_a", dout_a, 64'd0);
    chk("midrst_cnt_a", 64'(cnt_a), 64'd0);
    chk("midrst_dov_b", 64'(dov_b), 64'd0);
    chk("midrst_frz_b", 64'(frz_b), 64'd0);
    chk("midrst_ready_a", 64'(ready_a), 64'd0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send({32'h0, 32'hDEADBEEF});
    chk("post_rst_key", dout_a, 64'h00000000_DEADBEEF);

    for (int i = 0; i < 3000; i++) begin
      key_start     = ($urandom_range(0, 49) == 0);
      key_abort     = ($urandom_range(0, 79) == 0);
      key_in_valid  = ($urandom_range(0, 3) != 0);
      key_in_bit    = 1'($urandom);
      data_in_valid = 1'($urandom);
      data_in       = {$urandom, $urandom};
      step();
      if (i % 600 == 599) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
